// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets NREQ requesters share one FIFO
// write port. Grant, write strobe and write data are combinational, so a
// beat costs no extra latency. gnt_id and beat_cnt report accepted beats.
//
// Build option: define FIFO_ARB_BURST_EN to add a burst lock. After a
// requester wins, it keeps the port for up to BURST_LEN beats, or until it
// drops its request. Without the macro, every accepted beat rotates the
// round-robin pointer.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [WIDTH-1:0]        fifo_din,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [15:0]             beat_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_cfg
    $error("fifo_wr_arb: NREQ must be 2..8 and BURST_LEN must be 1..16");
  end

  // Step an index forward by one, wrapping from NREQ-1 back to 0.
  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(NREQ - 1)) ? '0 : v + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] base;       // index where the round-robin search starts
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic [PTR_W-1:0] sel;        // index that actually receives the grant
  logic             lock_hold;  // lock owner is still requesting
  logic             beat;

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  lock_state_t      state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  assign lock_hold = (state == LOCK) && req[owner];
  // When a lock is abandoned, the search resumes right after the old owner.
  assign base      = (state == LOCK) ? inc_wrap(owner) : ptr;
  assign sel       = lock_hold ? owner : win;
`else
  assign lock_hold = 1'b0;
  assign base      = ptr;
  assign sel       = win;
`endif

  // Round-robin search: pick the first active request at or above base, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = base;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
      scan_idx = inc_wrap(scan_idx);
    end
  end

  // Grant is suppressed during reset and while the FIFO is full.
  always_comb begin
    gnt = '0;
    if (!rst && !fifo_full && (lock_hold || win_vld)) begin
      gnt[sel] = 1'b1;
    end
  end

  assign beat    = |gnt;
  assign fifo_wr = beat;

  // Route the granted requester's data to the FIFO. Drive zero when there is no grant.
  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_din = din[i*WIDTH +: WIDTH];
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // Next-state logic for the pointer and the burst lock. All of it holds while the FIFO is full.
  always_comb begin
    ptr_nxt       = ptr;
    state_nxt     = state;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    if (!fifo_full) begin
      if (lock_hold) begin
        if (burst_cnt + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
          ptr_nxt       = inc_wrap(owner);
        end else begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end else begin
        // The owner dropped its request: release the lock.
        if (state == LOCK) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
          ptr_nxt       = inc_wrap(owner);
        end
        if (beat) begin
          if (BURST_LEN > 1) begin
            state_nxt     = LOCK;
            owner_nxt     = win;
            burst_cnt_nxt = CNT_W'(1);
          end else begin
            ptr_nxt = inc_wrap(win);
          end
        end
      end
    end
  end
`else
  // Next-state logic for the pointer: it rotates past the winner of each accepted beat.
  always_comb begin
    ptr_nxt = ptr;
    if (beat) ptr_nxt = inc_wrap(win);
  end
`endif

  // State registers with synchronous reset. Status updates only on accepted beats.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ptr       <= '0;
      gnt_id    <= '0;
      beat_cnt  <= '0;
`ifdef FIFO_ARB_BURST_EN
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
`endif
    end else begin
      ptr       <= ptr_nxt;
`ifdef FIFO_ARB_BURST_EN
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
`endif
      if (beat) begin
        gnt_id   <= sel;
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench for fifo_wr_arb with a scoreboard.
// Each stimulus step pushes the hand-computed grant and data it expects.
// A negedge monitor pops that entry whenever the DUT writes to the FIFO.
// Registered status is compared at the start of every step.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_din;
  logic [1:0]            gnt_id;
  logic [15:0]           beat_cnt;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          step_no = 0;
  bit          done = 1'b0;
  logic [15:0] exp_beats = '0;  // includes the step currently being driven
  logic [1:0]  exp_id    = '0;
  logic [15:0] chk_beats = '0;  // state as of the last completed edge
  logic [1:0]  chk_id    = '0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .fifo_full(fifo_full),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .gnt_id   (gnt_id),
    .beat_cnt (beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Drive one cycle: r = requests, f = full, eg = expected one-hot grant, rs = reset.
  task automatic step(input logic [3:0] r, input logic f, input logic [3:0] eg,
                      input logic rs = 1'b0);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    chk_beats = exp_beats;
    chk_id    = exp_id;
    check("beat_cnt", 32'(beat_cnt), 32'(chk_beats));
    check("gnt_id", 32'(gnt_id), 32'(chk_id));
    step_no++;
    rst       = rs;
    req       = r;
    fifo_full = f;
    for (int i = 0; i < NREQ; i++) din[i*WIDTH +: WIDTH] = 8'(step_no * 16 + i);
    if (rs) begin
      exp_beats = '0;
      exp_id    = '0;
    end else if (eg != 4'b0000) begin
      w = 0;
      for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
      e.gnt  = eg;
      e.data = din[w*WIDTH +: WIDTH];
      exp_q.push_back(e);
      exp_beats = exp_beats + 16'd1;
      exp_id    = 2'(w);
    end
  endtask

  // Monitor: compare every FIFO write against the scoreboard, and check that nothing is written while full.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (fifo_full) check("wr_while_full", 32'(fifo_wr), 32'd0);
      if (fifo_wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(e.gnt));
          check("fifo_din", 32'(fifo_din), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, beats=%0d", beat_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; fifo_full = 1'b0; din = '0;

    // Reset: outputs stay quiet even though every requester is active.
    step(4'b1111, 1'b0, 4'b0000, 1'b1);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst_fifo_din", 32'(fifo_din), 32'd0);
    step(4'b0000, 1'b0, 4'b0000);

`ifdef FIFO_ARB_BURST_EN
    // Requesters 0 and 1 both active: four beats to 0, then four beats to 1.
    repeat (4) step(4'b0011, 1'b0, 4'b0001);
    repeat (4) step(4'b0011, 1'b0, 4'b0010);
    // ptr=2. Owner 2 drops after two beats, so 3 wins in that same cycle.
    step(4'b1100, 1'b0, 4'b0100);
    step(4'b1100, 1'b0, 4'b0100);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b0000, 1'b0, 4'b0000);  // owner 3 drops; ptr -> 0
    // Full in the middle of a lock: lock and counter hold, then the burst finishes.
    step(4'b0001, 1'b0, 4'b0001);
    step(4'b0011, 1'b1, 4'b0000);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 4'b0010);  // lock owner 1, count 1
    // Reset during a lock beat. Afterwards, 0 wins: without the reset, the lock would release to 2.
    step(4'b0011, 1'b0, 4'b0000, 1'b1);
    #1;
    check("rst_lock_gnt", 32'(gnt), 32'd0);
    check("rst_lock_fifo_wr", 32'(fifo_wr), 32'd0);
    step(4'b0101, 1'b0, 4'b0001);
`else
    // Every requester active: strict rotation.
    repeat (2) begin
      step(4'b1111, 1'b0, 4'b0001);
      step(4'b1111, 1'b0, 4'b0010);
      step(4'b1111, 1'b0, 4'b0100);
      step(4'b1111, 1'b0, 4'b1000);
    end
    // Full toggles every cycle: 0 and 2 alternate, and ptr holds through the full cycles.
    repeat (2) begin
      step(4'b0101, 1'b0, 4'b0001);
      step(4'b0101, 1'b1, 4'b0000);
      step(4'b0101, 1'b0, 4'b0100);
      step(4'b0101, 1'b1, 4'b0000);
    end
    // ptr=3. Requester 1 withdraws before it is granted: no beat and no state change.
    step(4'b0010, 1'b1, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 4'b1000);
    step(4'b0110, 1'b0, 4'b0010);
    step(4'b0110, 1'b0, 4'b0100);
    step(4'b0011, 1'b0, 4'b0001);  // search wraps from 3 to 0
    step(4'b1000, 1'b0, 4'b1000);
    // One requester active: it is granted every cycle.
    repeat (5) step(4'b0100, 1'b0, 4'b0100);
    // ptr=3. Move ptr to 2, then reset. Afterwards the lowest requester wins, not 3.
    step(4'b1111, 1'b0, 4'b1000);
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 1'b0, 4'b0000, 1'b1);
    #1;
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_fifo_wr", 32'(fifo_wr), 32'd0);
    step(4'b1011, 1'b0, 4'b0001);
`endif

    // Run the beat counter to 0xFFFF, then one more beat wraps it to 0.
    while (exp_beats != 16'hFFFF) step(4'b0001, 1'b0, 4'b0001);
    step(4'b0001, 1'b0, 4'b0001);
    check("beat_cnt_max", 32'(beat_cnt), 32'h0000_FFFF);
    step(4'b0000, 1'b0, 4'b0000);
    check("beat_cnt_wrap", 32'(beat_cnt), 32'h0000_0000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, is the number of write requesters sharing one FIFO write port (2..8).
REQ-002 Parameter WIDTH, default 8, is the data width of each requester and of the FIFO.
REQ-003 Parameter BURST_LEN, default 4, is the maximum number of beats per burst lock (1..16); it is used only when FIFO_ARB_BURST_EN is defined.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  is the reset: synchronous and active-high.
REQ-006 req  input  NREQ  carries the per-requester write request; req[i] is high while requester i holds valid data.
REQ-007 din  input  NREQ*WIDTH  carries requester i data at bits [i*WIDTH +: WIDTH], which stays stable while req[i] is high and ungranted.
REQ-008 gnt  output  NREQ  is the grant, one-hot or zero; a beat is accepted when req[i] && gnt[i].
REQ-009 fifo_full  input  1  is the full flag from the downstream FIFO.
REQ-010 fifo_wr  output  1  is the write strobe to the FIFO.
REQ-011 fifo_din  output  WIDTH  is the write data to the FIFO.
REQ-012 gnt_id  output  $clog2(NREQ)  is the registered index of the last accepted requester.
REQ-013 beat_cnt  output  16  is the registered count of accepted beats since reset.

Function
REQ-014 gnt SHALL be combinational from req, fifo_full, rr pointer and lock state, and SHALL be all-zero whenever fifo_full=1 or rst=1.
REQ-015 fifo_wr SHALL equal |gnt, and fifo_din SHALL equal the din slice of the granted requester (zero when there is no grant); the FIFO samples both on the same edge, so added latency is zero cycles.
REQ-016 Arbitration SHALL be round-robin: the winner is the first asserted req[i] searching upward from rr pointer ptr, wrapping NREQ-1 -> 0.
REQ-017 On each accepted beat outside a lock, ptr SHALL become (winner+1) mod NREQ on the next edge; with no beat accepted, ptr SHALL hold.
REQ-018 When fifo_full=1, ptr, the lock state, the burst counter, gnt_id and beat_cnt SHALL hold.
REQ-019 gnt_id SHALL load the winner index on each accepted beat, one cycle after acceptance.
REQ-020 beat_cnt SHALL increment by 1 per accepted beat and wrap 0xFFFF -> 0x0000.
REQ-021 A requester deasserting req before being granted SHALL cause no beat and no state change.
REQ-022 A continuously requesting requester SHALL be granted within NREQ accepted beats, or within NREQ*BURST_LEN accepted beats when burst lock is enabled.
REQ-023 With exactly one requester active, that requester SHALL be granted every non-full cycle, for a throughput of 1 beat/cycle.

Reset
REQ-024 While rst=1: gnt=0, fifo_wr=0, fifo_din=0; on the edge, ptr<=0, lock state<=IDLE, burst counter<=0, gnt_id<=0, beat_cnt<=0.
REQ-025 Reset asserted mid-burst SHALL abandon the lock, and no beat SHALL be accepted in that cycle.

Configuration
REQ-026 Macro FIFO_ARB_BURST_EN SHALL compile in the burst lock FSM with states IDLE and LOCK.
REQ-027 With the macro defined, an accepted beat from winner w in IDLE with BURST_LEN>1 SHALL enter LOCK with owner=w and count=1, and ptr SHALL hold.
REQ-028 With the macro defined, in LOCK only the owner SHALL be grantable, and each accepted beat SHALL increment count.
REQ-029 With the macro defined, LOCK SHALL exit to IDLE with ptr<=owner+1 after the beat that makes count=BURST_LEN.
REQ-030 With the macro defined, LOCK SHALL also exit to IDLE with ptr<=owner+1 in any non-full cycle where req[owner]=0; in that cycle arbitration SHALL proceed normally from owner+1.
REQ-031 Without the macro, there SHALL be no LOCK state and every accepted beat rotates ptr per REQ-017.

Verification
REQ-032 Scenario: req=4'b1111 with fifo_full=0 for 8 cycles, macro off -> gnt sequence 0001,0010,0100,1000 repeating, and beat_cnt=8.
REQ-033 Scenario: req=4'b0101, fifo_full toggles 0/1 each cycle -> grants only in full=0 cycles, alternating requesters 0 and 2, and ptr held across full cycles.
REQ-034 Scenario: macro on, BURST_LEN=4, req=4'b0011 -> 4 consecutive grants to requester 0, then 4 to requester 1, with fifo_din matching each din slice.
REQ-035 Scenario: macro on, requester 2 drops req after 2 beats of a lock -> lock released, requester 3 granted in the same cycle if requesting.
REQ-036 Scenario: rst asserted during a LOCK beat -> gnt=0 and fifo_wr=0 that cycle; after rst, ptr=0, beat_cnt=0 and the first grant goes to the lowest requesting index.
REQ-037 Scenario: 65536 accepted beats -> beat_cnt wraps to 0x0000, and the FIFO never receives fifo_wr while fifo_full=1.
